// File: rtl/int_sequencer_if.sv
// Coprocessor-side bundle for the interrupt sequencer.
// The sequencer (master) consumes the coprocessor request/status and drives
// its write strobes; the coprocessor register block is the slave.
//   int_req     coprocessor `int`: enabled, unmasked request pending
//   ints[2:0]   highest pending level, 0..3
//   irs[2:0]    in-service bits
//   epc[31:0]   current EPC value
//   irs_set_en / irs_clr_en / irs_w_mask   IRS write strobes and mask
//   ie_w_en / ie_w_data                    IE write
//   epc_w_en / epc_w_data                  EPC write
interface int_sequencer_if;
    logic        int_req;
    logic [2:0]  ints;
    logic [2:0]  irs;
    logic [31:0] epc;
    logic        irs_set_en;
    logic        irs_clr_en;
    logic [2:0]  irs_w_mask;
    logic        ie_w_en;
    logic        ie_w_data;
    logic        epc_w_en;
    logic [31:0] epc_w_data;

    modport master (
        input  int_req, ints, irs, epc,
        output irs_set_en, irs_clr_en, irs_w_mask,
               ie_w_en, ie_w_data, epc_w_en, epc_w_data
    );

    modport slave (
        output int_req, ints, irs, epc,
        input  irs_set_en, irs_clr_en, irs_w_mask,
               ie_w_en, ie_w_data, epc_w_en, epc_w_data
    );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry/return sequencer.
// Takes a coprocessor interrupt request at an instruction boundary, saves the
// resume PC to EPC, marks the level in service, masks IE and redirects fetch
// to the level's vector. On eret it redirects to EPC, re-enables IE and clears
// the highest in-service bit.
//   clk, rst         clock, synchronous active-high reset
//   cop              coprocessor request/status in, write strobes out
//   boundary         pipeline at an instruction boundary, resume_pc valid
//   resume_pc        next instruction address (saved to EPC on entry)
//   eret             return-from-interrupt committing (qualified by boundary)
//   redirect         one-cycle fetch redirect + flush
//   redirect_pc      redirect target
//   busy             sequencer active, fetch holds PC
//   cur_level        level latched at the last entry
//
// state  | meaning
// IDLE   | waiting for boundary with eret or an interrupt request
// SAVE   | write EPC, set IRS level bit, clear IE
// VECTOR | redirect to the level vector, optionally re-enable IE
// RETURN | redirect to EPC, set IE, clear highest in-service bit
module int_sequencer #(
    parameter logic [31:0] VEC1    = 32'h0000_0040,
    parameter logic [31:0] VEC2    = 32'h0000_0080,
    parameter logic [31:0] VEC3    = 32'h0000_00C0,
    parameter bit          NEST_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    int_sequencer_if.master        cop,
    input  logic                   boundary,
    input  logic [31:0]            resume_pc,
    input  logic                   eret,
    output logic                   redirect,
    output logic [31:0]            redirect_pc,
    output logic                   busy,
    output logic [1:0]             cur_level
);

    typedef enum logic [1:0] {IDLE, SAVE, VECTOR, RETURN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lvl_q;
    logic [31:0] pc_q;
    logic        take_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lvl_q   <= 2'd0;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            if (take_int) begin
                lvl_q <= cop.ints[1:0];
                pc_q  <= resume_pc;
            end
        end
    end

    always_comb begin
        state_d        = IDLE;
        take_int       = 1'b0;
        cop.irs_set_en = 1'b0;
        cop.irs_clr_en = 1'b0;
        cop.irs_w_mask = 3'b000;
        cop.ie_w_en    = 1'b0;
        cop.ie_w_data  = 1'b0;
        cop.epc_w_en   = 1'b0;
        cop.epc_w_data = 32'd0;
        redirect       = 1'b0;
        redirect_pc    = 32'd0;
        busy           = 1'b0;

        case (state_q)
            IDLE: begin
                // eret takes precedence; a request left pending is taken
                // at the first boundary after the return.
                if (boundary && eret) begin
                    state_d = RETURN;
                end else if (boundary && cop.int_req && (cop.ints != 3'd0)) begin
                    state_d  = SAVE;
                    take_int = 1'b1;
                end
            end

            SAVE: begin
                busy           = 1'b1;
                cop.epc_w_en   = 1'b1;
                cop.epc_w_data = pc_q;
                cop.irs_set_en = 1'b1;
                case (lvl_q)
                    2'd1:    cop.irs_w_mask = 3'b001;
                    2'd2:    cop.irs_w_mask = 3'b010;
                    2'd3:    cop.irs_w_mask = 3'b100;
                    default: cop.irs_w_mask = 3'b000;
                endcase
                cop.ie_w_en    = 1'b1;
                cop.ie_w_data  = 1'b0;
                state_d        = VECTOR;
            end

            VECTOR: begin
                busy     = 1'b1;
                redirect = 1'b1;
                case (lvl_q)
                    2'd1:    redirect_pc = VEC1;
                    2'd2:    redirect_pc = VEC2;
                    2'd3:    redirect_pc = VEC3;
                    default: redirect_pc = 32'd0;
                endcase
                if (NEST_EN) begin
                    cop.ie_w_en   = 1'b1;
                    cop.ie_w_data = 1'b1;
                end
                state_d = IDLE;
            end

            RETURN: begin
                busy          = 1'b1;
                redirect      = 1'b1;
                redirect_pc   = cop.epc;
                cop.ie_w_en   = 1'b1;
                cop.ie_w_data = 1'b1;
                // Keep-mask: zero only the highest in-service bit.
                // A spurious eret (irs==0) still redirects but clears nothing.
                if (cop.irs[2]) begin
                    cop.irs_clr_en = 1'b1;
                    cop.irs_w_mask = 3'b011;
                end else if (cop.irs[1]) begin
                    cop.irs_clr_en = 1'b1;
                    cop.irs_w_mask = 3'b101;
                end else if (cop.irs[0]) begin
                    cop.irs_clr_en = 1'b1;
                    cop.irs_w_mask = 3'b110;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign cur_level = lvl_q;

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;

    typedef struct packed {
        logic        irs_set_en;
        logic        irs_clr_en;
        logic [2:0]  irs_w_mask;
        logic        ie_w_en;
        logic        ie_w_data;
        logic        epc_w_en;
        logic [31:0] epc_w_data;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        busy;
        logic [1:0]  cur_level;
    } outs_t;

    localparam int K_SAVE = 1;
    localparam int K_VEC  = 2;
    localparam int K_RET  = 3;

    typedef struct {
        int          kind;
        logic [1:0]  lvl;
        logic [31:0] pc;
    } act_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_req_d;
    logic [2:0]  ints_d;
    logic [2:0]  irs_d;
    logic [31:0] epc_d;
    logic        boundary;
    logic [31:0] resume_pc;
    logic        eret;

    logic        redir_a, redir_b, busy_a, busy_b;
    logic [31:0] redir_pc_a, redir_pc_b;
    logic [1:0]  lvl_a, lvl_b;
    outs_t       got_a, got_b;

    int n_vec = 0;
    int n_err = 0;

    act_t       q[$];
    logic [1:0] lvl_m;

    always #5 clk = ~clk;

    int_sequencer_if cop_a ();
    int_sequencer_if cop_b ();

    assign cop_a.int_req = int_req_d;
    assign cop_a.ints    = ints_d;
    assign cop_a.irs     = irs_d;
    assign cop_a.epc     = epc_d;
    assign cop_b.int_req = int_req_d;
    assign cop_b.ints    = ints_d;
    assign cop_b.irs     = irs_d;
    assign cop_b.epc     = epc_d;

    int_sequencer #(.NEST_EN(1'b1)) dut_nest (
        .clk(clk), .rst(rst), .cop(cop_a),
        .boundary(boundary), .resume_pc(resume_pc), .eret(eret),
        .redirect(redir_a), .redirect_pc(redir_pc_a),
        .busy(busy_a), .cur_level(lvl_a)
    );

    int_sequencer #(.NEST_EN(1'b0)) dut_flat (
        .clk(clk), .rst(rst), .cop(cop_b),
        .boundary(boundary), .resume_pc(resume_pc), .eret(eret),
        .redirect(redir_b), .redirect_pc(redir_pc_b),
        .busy(busy_b), .cur_level(lvl_b)
    );

    assign got_a = {cop_a.irs_set_en, cop_a.irs_clr_en, cop_a.irs_w_mask,
                    cop_a.ie_w_en, cop_a.ie_w_data, cop_a.epc_w_en, cop_a.epc_w_data,
                    redir_a, redir_pc_a, busy_a, lvl_a};
    assign got_b = {cop_b.irs_set_en, cop_b.irs_clr_en, cop_b.irs_w_mask,
                    cop_b.ie_w_en, cop_b.ie_w_data, cop_b.epc_w_en, cop_b.epc_w_data,
                    redir_b, redir_pc_b, busy_b, lvl_b};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the sequencer is a queue of scheduled busy cycles. Entry
    // schedules a save cycle then a vector cycle; eret schedules one return
    // cycle. An empty queue means idle with all strobes low.
    task automatic model_edge();
        bit was_idle;
        act_t a;
        if (rst) begin
            q.delete();
            lvl_m = 2'd0;
            return;
        end
        was_idle = (q.size() == 0);
        if (!was_idle) void'(q.pop_front());
        if (was_idle && boundary) begin
            if (eret) begin
                a.kind = K_RET; a.lvl = 2'd0; a.pc = 32'd0;
                q.push_back(a);
            end else if (int_req_d && ints_d != 3'd0) begin
                lvl_m  = ints_d[1:0];
                a.kind = K_SAVE; a.lvl = ints_d[1:0]; a.pc = resume_pc;
                q.push_back(a);
                a.kind = K_VEC;
                q.push_back(a);
            end
        end
    endtask

    function automatic outs_t expect_outs(input bit nest);
        outs_t e;
        bit    found;
        e = '0;
        e.cur_level = lvl_m;
        if (q.size() != 0) begin
            e.busy = 1'b1;
            case (q[0].kind)
                K_SAVE: begin
                    e.epc_w_en   = 1'b1;
                    e.epc_w_data = q[0].pc;
                    e.irs_set_en = 1'b1;
                    e.irs_w_mask = 3'(1 << (int'(q[0].lvl) - 1));
                    e.ie_w_en    = 1'b1;
                    e.ie_w_data  = 1'b0;
                end
                K_VEC: begin
                    e.redirect    = 1'b1;
                    e.redirect_pc = 32'h40 * 32'(q[0].lvl);
                    e.ie_w_en     = nest;
                    e.ie_w_data   = nest;
                end
                default: begin
                    e.redirect    = 1'b1;
                    e.redirect_pc = epc_d;
                    e.ie_w_en     = 1'b1;
                    e.ie_w_data   = 1'b1;
                    found = 1'b0;
                    for (int b = 2; b >= 0; b--) begin
                        if (!found && irs_d[b]) begin
                            found        = 1'b1;
                            e.irs_clr_en = 1'b1;
                            e.irs_w_mask = 3'b111 ^ 3'(1 << b);
                        end
                    end
                end
            endcase
        end
        return e;
    endfunction

    task automatic compare(input string p, input outs_t g, input outs_t e);
        chk({p, ".irs_set_en"},  32'(g.irs_set_en),  32'(e.irs_set_en));
        chk({p, ".irs_clr_en"},  32'(g.irs_clr_en),  32'(e.irs_clr_en));
        chk({p, ".irs_w_mask"},  32'(g.irs_w_mask),  32'(e.irs_w_mask));
        chk({p, ".ie_w_en"},     32'(g.ie_w_en),     32'(e.ie_w_en));
        chk({p, ".ie_w_data"},   32'(g.ie_w_data),   32'(e.ie_w_data));
        chk({p, ".epc_w_en"},    32'(g.epc_w_en),    32'(e.epc_w_en));
        chk({p, ".epc_w_data"},  g.epc_w_data,       e.epc_w_data);
        chk({p, ".redirect"},    32'(g.redirect),    32'(e.redirect));
        chk({p, ".redirect_pc"}, g.redirect_pc,      e.redirect_pc);
        chk({p, ".busy"},        32'(g.busy),        32'(e.busy));
        chk({p, ".cur_level"},   32'(g.cur_level),   32'(e.cur_level));
    endtask

    // Drive one cycle of inputs, let the edge sample them, then check both builds.
    task automatic step(input bit r, input bit ir, input logic [2:0] is,
                        input logic [2:0] irs_v, input logic [31:0] epc_v,
                        input bit bnd, input logic [31:0] rpc, input bit er);
        @(negedge clk);
        rst       = r;
        int_req_d = ir;
        ints_d    = is;
        irs_d     = irs_v;
        epc_d     = epc_v;
        boundary  = bnd;
        resume_pc = rpc;
        eret      = er;
        @(posedge clk);
        model_edge();
        #1;
        compare("nest", got_a, expect_outs(1'b1));
        compare("flat", got_b, expect_outs(1'b0));
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; int_req_d = 1'b0; ints_d = 3'd0; irs_d = 3'd0; epc_d = 32'd0;
        boundary = 1'b0; resume_pc = 32'd0; eret = 1'b0;
        q.delete();
        lvl_m = 2'd0;

        step(1'b1, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 3'd2, 3'd7, 32'hFFFF_FFFF, 1'b1, 32'h55, 1'b1);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_redirect_pc", redir_pc_a, 32'd0);

        // Level 2 entry
        step(1'b0, 1'b1, 3'd2, 3'd0, 32'd0, 1'b1, 32'h1234, 1'b0);
        chk("l2_epc_data", cop_a.epc_w_data, 32'h1234);
        chk("l2_set_mask", 32'(cop_a.irs_w_mask), 32'b010);
        chk("l2_ie_data", 32'(cop_a.ie_w_data), 32'd0);
        idle_step();
        chk("l2_vec", redir_pc_a, 32'h80);
        chk("l2_nest_ie", 32'(cop_a.ie_w_data), 32'd1);
        chk("l2_flat_ie_en", 32'(cop_b.ie_w_en), 32'd0);
        idle_step();
        chk("l2_done", 32'(busy_a), 32'd0);

        // Return with two levels in service
        step(1'b0, 1'b0, 3'd0, 3'b110, 32'h1234, 1'b1, 32'h2000, 1'b1);
        chk("ret_pc", redir_pc_a, 32'h1234);
        chk("ret_clr_mask", 32'(cop_a.irs_w_mask), 32'b011);
        chk("ret_clr_en", 32'(cop_a.irs_clr_en), 32'd1);
        idle_step();

        // Simultaneous eret and request: return first, request afterwards
        step(1'b0, 1'b1, 3'd3, 3'b001, 32'h700, 1'b1, 32'h300, 1'b1);
        chk("sim_ret_pc", redir_pc_a, 32'h700);
        chk("sim_no_set", 32'(cop_a.irs_set_en), 32'd0);
        step(1'b0, 1'b1, 3'd3, 3'b000, 32'd0, 1'b0, 32'h300, 1'b0);
        step(1'b0, 1'b1, 3'd3, 3'b000, 32'd0, 1'b1, 32'h300, 1'b0);
        chk("sim_set_mask", 32'(cop_a.irs_w_mask), 32'b100);
        idle_step();
        chk("sim_vec", redir_pc_a, 32'hC0);
        idle_step();

        // Spurious eret
        step(1'b0, 1'b0, 3'd0, 3'd0, 32'h40, 1'b1, 32'h0, 1'b1);
        chk("spur_pc", redir_pc_a, 32'h40);
        chk("spur_clr", 32'(cop_a.irs_clr_en), 32'd0);
        idle_step();

        // Request without boundary is ignored
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 3'd1, 3'd0, 32'd0, 1'b0, 32'h900, 1'b0);
            chk("noboundary_busy", 32'(busy_a), 32'd0);
        end
        step(1'b0, 1'b1, 3'd1, 3'd0, 32'd0, 1'b1, 32'h900, 1'b0);
        chk("boundary_save", 32'(cop_a.irs_w_mask), 32'b001);

        // Reset during SAVE
        step(1'b1, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        chk("abort_epc_en", 32'(cop_a.epc_w_en), 32'd0);
        chk("abort_redirect", 32'(redir_a), 32'd0);
        idle_step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 59) == 0,
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 3)),
                 3'($urandom),
                 $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)),
                 $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
